// File: rtl/lc3_operate_unit.sv
// LC-3 operate-instruction unit: ADD/AND/NOT with register or sign-extended immediate operand.
// Owns the GPR file and N/Z/P condition codes; one instruction in flight under valid/ready.
module lc3_operate_unit #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned REG_AW   = 3,
   parameter int unsigned IMM_W    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        op,
   input  logic              imm_mode,
   input  logic [REG_AW-1:0] dr,
   input  logic [REG_AW-1:0] sr1,
   input  logic [REG_AW-1:0] sr2,
   input  logic [IMM_W-1:0]  imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [REG_AW-1:0] out_dr,
   output logic              illegal_op,
   output logic [2:0]        nzp,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   localparam logic [1:0] OpAdd = 2'b00;
   localparam logic [1:0] OpAnd = 2'b01;
   localparam logic [1:0] OpNot = 2'b10;
   localparam logic [REG_AW:0] NumRegs = (REG_AW + 1)'(NUM_REGS);

   state_e              state_q;
   logic [1:0]          op_q;
   logic [REG_AW-1:0]   dr_q;
   logic [DATA_W-1:0]   a_q, b_q;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [2:0]          nzp_q;
   logic [DATA_W-1:0]   out_result_q;
   logic [REG_AW-1:0]   out_dr_q;
   logic                illegal_q;

   logic [DATA_W-1:0]   sr1_val, sr2_val, imm_sext, b_sel, exec_result;
   logic [2:0]          exec_nzp;
   logic                exec_legal;

   // Addresses beyond NUM_REGS read as zero and are never written.
   always_comb begin
      sr1_val  = '0;
      sr2_val  = '0;
      dbg_data = '0;
      if ({1'b0, sr1} < NumRegs)      sr1_val  = regs_q[sr1];
      if ({1'b0, sr2} < NumRegs)      sr2_val  = regs_q[sr2];
      if ({1'b0, dbg_addr} < NumRegs) dbg_data = regs_q[dbg_addr];
   end

   assign imm_sext = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
   assign b_sel    = imm_mode ? imm_sext : sr2_val;

   always_comb begin
      exec_result = '0;
      exec_legal  = 1'b1;
      unique case (op_q)
         OpAdd:   exec_result = a_q + b_q;
         OpAnd:   exec_result = a_q & b_q;
         OpNot:   exec_result = ~a_q;
         default: exec_legal  = 1'b0;
      endcase
   end

   always_comb begin
      if (exec_result[DATA_W-1])   exec_nzp = 3'b100;
      else if (exec_result == '0)  exec_nzp = 3'b010;
      else                         exec_nzp = 3'b001;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         op_q         <= '0;
         dr_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         nzp_q        <= 3'b010;
         out_result_q <= '0;
         out_dr_q     <= '0;
         illegal_q    <= 1'b0;
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  op_q    <= op;
                  dr_q    <= dr;
                  a_q     <= sr1_val;
                  b_q     <= b_sel;
                  state_q <= StExec;
               end
            end
            StExec: begin
               out_result_q <= exec_result;
               out_dr_q     <= dr_q;
               illegal_q    <= ~exec_legal;
               if (exec_legal) begin
                  if ({1'b0, dr_q} < NumRegs) regs_q[dr_q] <= exec_result;
                  nzp_q <= exec_nzp;
               end
               state_q <= StDone;
            end
            StDone: begin
               if (out_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign out_valid  = (state_q == StDone);
   assign out_result = out_result_q;
   assign out_dr     = out_dr_q;
   assign illegal_op = illegal_q;
   assign nzp        = nzp_q;

endmodule

// File: tb/tb_lc3_operate_unit.sv
// Self-checking bench for lc3_operate_unit: directed spec scenarios then random instructions
// against an arithmetic reference model of the register file and condition codes.
module tb_lc3_operate_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = '0;
   logic        imm_mode = 1'b0;
   logic [2:0]  dr = '0, sr1 = '0, sr2 = '0;
   logic [4:0]  imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_result;
   logic [2:0]  out_dr;
   logic        illegal_op;
   logic [2:0]  nzp;
   logic [2:0]  dbg_addr = '0;
   logic [15:0] dbg_data;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] m_regs [8];
   logic [2:0]  m_nzp;

   lc3_operate_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .imm_mode   (imm_mode),
      .dr         (dr),
      .sr1        (sr1),
      .sr2        (sr2),
      .imm        (imm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_dr     (out_dr),
      .illegal_op (illegal_op),
      .nzp        (nzp),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sext5(input logic [4:0] v);
      int iv;
      iv = int'(v);
      if (iv >= 16) iv = iv - 32;
      return 16'(iv);
   endfunction

   function automatic logic [2:0] cc_of(input logic [15:0] v);
      if ($signed(v) < 0) return 3'b100;
      if (v == 16'h0)     return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic [15:0] model_op(input logic [1:0] o, input logic [15:0] a,
                                            input logic [15:0] b);
      int unsigned s;
      case (o)
         2'b00: begin
            s = (int'(a) + int'(b)) % 65536;
            return 16'(s);
         end
         2'b01:   return a & b;
         2'b10:   return ~a;
         default: return 16'h0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_nzp = 3'b010;
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
      dbg_addr = a;
      #1;
      check(tag, dbg_data, exp);
   endtask

   // One full instruction: accept, two-edge latency, optional back-pressure, handshake.
   task automatic run(input logic [1:0] o, input logic im, input logic [2:0] d,
                      input logic [2:0] s1, input logic [2:0] s2, input logic [4:0] i,
                      input int hold);
      logic [15:0] a, b, res;
      logic        legal;
      a     = m_regs[s1];
      b     = im ? sext5(i) : m_regs[s2];
      legal = (o != 2'b11);
      res   = legal ? model_op(o, a, b) : 16'h0;

      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      in_valid = 1'b1; op = o; imm_mode = im; dr = d; sr1 = s1; sr2 = s2; imm = i;
      @(negedge clk);
      in_valid = 1'b0;
      op = 2'($urandom); imm_mode = 1'($urandom); dr = 3'($urandom);
      sr1 = 3'($urandom); sr2 = 3'($urandom); imm = 5'($urandom);
      check("out_valid_exec", out_valid, 0);
      check("in_ready_exec", in_ready, 0);
      if (legal) begin
         m_regs[d] = res;
         m_nzp     = cc_of(res);
      end
      @(negedge clk);
      check("out_valid_done", out_valid, 1);
      check("out_result", out_result, res);
      check("out_dr", out_dr, d);
      check("illegal_op", illegal_op, !legal);
      check("nzp", nzp, m_nzp);
      check("in_ready_done", in_ready, 0);
      chk_reg("dbg_wb", d, m_regs[d]);
      repeat (hold) begin
         @(negedge clk);
         check("out_valid_hold", out_valid, 1);
         check("out_result_hold", out_result, res);
         check("in_ready_hold", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after", out_valid, 0);
      check("in_ready_after", in_ready, 1);
   endtask

   initial begin
      model_reset();
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_dr", out_dr, 0);
      check("rst_illegal", illegal_op, 0);
      check("rst_nzp", nzp, 3'b010);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      chk_reg("rst_r3", 3'd3, 16'h0);

      run(2'b00, 1'b1, 3'd1, 3'd0, 3'd0, 5'd5, 0);
      chk_reg("r1_is_5", 3'd1, 16'h0005);
      check("nzp_pos", nzp, 3'b001);
      run(2'b00, 1'b1, 3'd2, 3'd1, 3'd0, 5'b11010, 0);
      chk_reg("r2_is_ffff", 3'd2, 16'hFFFF);
      check("nzp_neg", nzp, 3'b100);
      run(2'b00, 1'b0, 3'd3, 3'd2, 3'd1, 5'd0, 1);
      chk_reg("r3_wrap", 3'd3, 16'h0004);
      run(2'b00, 1'b1, 3'd6, 3'd0, 3'd0, 5'd0, 0);
      chk_reg("r6_zero", 3'd6, 16'h0000);
      check("nzp_zero", nzp, 3'b010);
      run(2'b01, 1'b0, 3'd4, 3'd2, 3'd1, 5'd0, 0);
      chk_reg("r4_and", 3'd4, 16'h0005);
      run(2'b10, 1'b1, 3'd5, 3'd1, 3'd7, 5'd3, 0);
      chk_reg("r5_not", 3'd5, 16'hFFFA);
      check("nzp_not", nzp, 3'b100);
      run(2'b11, 1'b0, 3'd1, 3'd2, 3'd3, 5'd0, 5);
      chk_reg("r1_kept", 3'd1, 16'h0005);
      check("nzp_kept", nzp, 3'b100);

      // Reset during EXEC of ADD R7,R1,#1 must abort the writeback.
      @(negedge clk);
      in_valid = 1'b1; op = 2'b00; imm_mode = 1'b1; dr = 3'd7; sr1 = 3'd1; imm = 5'd1;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_in_ready", in_ready, 1);
      check("abort_nzp", nzp, 3'b010);
      chk_reg("abort_r7", 3'd7, 16'h0);
      chk_reg("abort_r1", 3'd1, 16'h0);

      // Reset while DONE drops out_valid asynchronously.
      run(2'b00, 1'b1, 3'd2, 3'd0, 3'd0, 5'd9, 0);
      @(negedge clk);
      in_valid = 1'b1; op = 2'b10; dr = 3'd3; sr1 = 3'd2;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("done_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("done_rst_out_valid", out_valid, 0);
      check("done_rst_result", out_result, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 80; n++) begin
         run(2'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             5'($urandom), int'($urandom_range(0, 2)));
      end
      @(negedge clk);
      for (int r = 0; r < 8; r++) chk_reg("final_sweep", 3'(r), m_regs[r]);
      check("final_nzp", nzp, m_nzp);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
